// File: rtl/parity_det_pkg.sv
// Shared definitions for the time-shared odd/odd parity detector.
// The context encoding and the per-bit transition function live here.
package parity_det_pkg;

    typedef enum logic [1:0] {
        CTX_A = 2'd0,
        CTX_B = 2'd1,
        CTX_C = 2'd2,
        CTX_D = 2'd3
    } ctx_e;

    // A 0 toggles the zero-parity bit (A<->B, C<->D) and a 1 toggles the
    // one-parity bit (A<->C, B<->D). D means both counts are odd.
    function automatic ctx_e next_ctx(input ctx_e state, input logic bit_in);
        case (state)
            CTX_A:   return bit_in ? CTX_C : CTX_B;
            CTX_B:   return bit_in ? CTX_D : CTX_A;
            CTX_C:   return bit_in ? CTX_A : CTX_D;
            CTX_D:   return bit_in ? CTX_B : CTX_C;
            default: return CTX_A;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. It grants the first eligible channel at or after the
// pointer and moves the pointer past the winner.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] eligible,
    input  logic           advance,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  gnt_idx
);

    logic [CW-1:0] ptr;
    logic          found;

    // NOTE: every output is given a default first, so no path leaves a value
    // unassigned. An unassigned path would infer a latch.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        // Two passes: first the channels at or above the pointer, then the
        // channels below it. This gives a wrap without computed indices.
        for (int i = 0; i < NCH; i++) begin
            if (!found && eligible[i] && i >= int'(ptr)) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = CW'(i);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!found && eligible[i] && i < int'(ptr)) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = CW'(i);
            end
        end
        if (!reset_n) begin
            gnt   = '0;
            found = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Then every
    // flop samples values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
        end
    end

endmodule

// File: rtl/parity_det_scheduler.sv
// One parity detector shared round-robin among NCH serial requesters.
// The top holds a 2-bit context per channel and registers the tagged results.
module parity_det_scheduler
    import parity_det_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] din,
    input  logic [NCH-1:0] clr,
    output logic [NCH-1:0] gnt,
    output logic           det_valid,
    output logic [CW-1:0]  det_ch,
    output logic           det_flag,
    output logic [NCH-1:0] ctx_is_d
);

    logic [NCH-1:0] eligible;
    logic [CW-1:0]  gnt_idx;
    logic           any_gnt;
    ctx_e           ctx     [NCH];
    ctx_e           ctx_nxt [NCH];
    ctx_e           srv_nxt;

    // A clearing channel must not be served in the same cycle. Its bit waits
    // and is later applied to the fresh A context.
    assign eligible = req & ~clr;
    assign any_gnt  = |gnt;

    rr_arbiter #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .eligible (eligible),
        .advance  (1'b1),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    always_comb begin
        srv_nxt = next_ctx(ctx[gnt_idx], din[gnt_idx]);
        for (int i = 0; i < NCH; i++) begin
            ctx_nxt[i] = ctx[i];
            if (clr[i]) begin
                ctx_nxt[i] = CTX_A;
            end else if (gnt[i]) begin
                ctx_nxt[i] = srv_nxt;
            end
        end
    end

    // NOTE: the context array is only NCH x 2 flops, and reset must return
    // every channel to A. So the array is reset like ordinary state, not left
    // as an uninitialised memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                ctx[i] <= CTX_A;
            end
            det_valid <= 1'b0;
            det_ch    <= '0;
            det_flag  <= 1'b0;
            ctx_is_d  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ctx[i]      <= ctx_nxt[i];
                ctx_is_d[i] <= (ctx_nxt[i] == CTX_D);
            end
            det_valid <= any_gnt;
            if (any_gnt) begin
                det_ch   <= gnt_idx;
                det_flag <= (srv_nxt == CTX_D);
            end
        end
    end

endmodule

// File: tb/tb_parity_det_scheduler.sv
// Directed, table-driven bench for parity_det_scheduler. Expected values are
// worked out by hand from the context transition table and round-robin order.
module tb_parity_det_scheduler;

    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int NV  = 23;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] req, din, clr;
    logic [NCH-1:0] gnt;
    logic           det_valid;
    logic [CW-1:0]  det_ch;
    logic           det_flag;
    logic [NCH-1:0] ctx_is_d;

    int checks   = 0;
    int failures = 0;

    parity_det_scheduler #(.NCH(NCH), .CW(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .din       (din),
        .clr       (clr),
        .gnt       (gnt),
        .det_valid (det_valid),
        .det_ch    (det_ch),
        .det_flag  (det_flag),
        .ctx_is_d  (ctx_is_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] clr;
        logic [3:0] gnt;   // combinational grant within the cycle
        logic       v;     // registered outputs after that cycle's edge
        logic [1:0] ch;
        logic       f;
        logic [3:0] isd;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // Round-robin: all requesting, din 0 (A->B) then din 1 (B->D)
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 4'b0000};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 4'b0000};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 4'b0000};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0, 4'b0000};
        vecs[4]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001};
        vecs[5]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b0011};
        vecs[6]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b1, 4'b0111};
        vecs[7]  = '{4'b1111, 4'b1111, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b1, 4'b1111};
        // Clear all channels together, no request: det_ch/det_flag hold
        vecs[8]  = '{4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000};
        // Single channel 2: bits 0,1 -> B then D
        vecs[9]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 4'b0000};
        vecs[10] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b1, 4'b0100};
        // Sparse wrap from pointer 3: ch0, ch2, ch0
        vecs[11] = '{4'b0101, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 4'b0100};
        vecs[12] = '{4'b0101, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 4'b0000};
        vecs[13] = '{4'b0101, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001};
        // Drive ch1 to D, then collide req with clr
        vecs[14] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 4'b0001};
        vecs[15] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b0011};
        vecs[16] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0001};
        vecs[17] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 4'b0001};
        // ch0 cleared while ch1 (C, din 1 -> A) is served
        vecs[18] = '{4'b0011, 4'b0010, 4'b0001, 4'b0010, 1'b1, 2'd1, 1'b0, 4'b0000};
        // Isolation: ch3 bits 1,1 and ch0 bits 0,1 interleaved; noise on other din
        vecs[19] = '{4'b1001, 4'b1001, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0, 4'b0000};
        vecs[20] = '{4'b1001, 4'b1000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 4'b0000};
        vecs[21] = '{4'b1001, 4'b1001, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0, 4'b0000};
        vecs[22] = '{4'b1001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001};

        // Reset with all channels requesting
        reset_n = 1'b0;
        req = 4'b1111;
        din = 4'b0000;
        clr = 4'b0000;
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_valid", 32'(det_valid), 32'h0);
        check("rst_ch", 32'(det_ch), 32'h0);
        check("rst_flag", 32'(det_flag), 32'h0);
        check("rst_isd", 32'(ctx_is_d), 32'h0);
        @(posedge clk); #1;
        check("rst_gnt_clocked", 32'(gnt), 32'h0);
        check("rst_valid_clocked", 32'(det_valid), 32'h0);
        req = 4'b0000;
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_valid", 32'(det_valid), 32'h0);

        for (int i = 0; i < NV; i++) begin
            req = vecs[i].req;
            din = vecs[i].din;
            clr = vecs[i].clr;
            #3;
            check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            @(posedge clk); #1;
            check($sformatf("v%0d_valid", i), 32'(det_valid), 32'(vecs[i].v));
            check($sformatf("v%0d_ch", i), 32'(det_ch), 32'(vecs[i].ch));
            check($sformatf("v%0d_flag", i), 32'(det_flag), 32'(vecs[i].f));
            check($sformatf("v%0d_isd", i), 32'(ctx_is_d), 32'(vecs[i].isd));
        end

        // Reset mid-stream: the in-flight valid is dropped and contexts go to A
        req = 4'b1111;
        din = 4'b1111;
        clr = 4'b0000;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_valid", 32'(det_valid), 32'h0);
        check("mid_rst_isd", 32'(ctx_is_d), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #2;
        check("post_rst_gnt0", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        check("post_rst_valid", 32'(det_valid), 32'h1);
        check("post_rst_ch", 32'(det_ch), 32'h0);
        check("post_rst_flag", 32'(det_flag), 32'h0);
        check("post_rst_isd", 32'(ctx_is_d), 32'h0);
        #2;
        check("post_rst_gnt1", 32'(gnt), 32'h2);
        @(posedge clk); #1;
        check("post_rst_ch1", 32'(det_ch), 32'h1);
        check("post_rst_flag1", 32'(det_flag), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parity_det_scheduler.md
Name: parity_det_scheduler

Overview:
- Time-shares one 4-state odd/odd parity detector among NCH serial bit-stream requesters.
- Stores a 2-bit FSM context per channel and serves one requester per cycle, round-robin.
- Each served bit advances that channel's context and returns a registered detection result tagged with the channel index.
- Sits between the serial input channels and the downstream event logic, replacing NCH copies of the detector FSM.

Parameters:
- NCH, 4, number of requesting channels (2..16).
- CW, 2, width of channel index; must equal clog2(NCH), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NCH  per-channel request; bit i high = din[i] valid this cycle.
- din  input  NCH  per-channel serial data bit, sampled only when granted.
- clr  input  NCH  per-channel synchronous context clear.
- gnt  output  NCH  one-hot combinational grant; requester i holds req/din until gnt[i].
- det_valid  output  1  registered; one served bit was processed last cycle.
- det_ch  output  CW  registered; channel index of that result.
- det_flag  output  1  registered; updated context of det_ch equals D.
- ctx_is_d  output  NCH  registered; bit i = channel i context currently D.

Behaviour:
- Context encoding (package constants): A=0, B=1, C=2, D=3.
  - A: din 0 -> B, din 1 -> C.
  - B: din 0 -> A, din 1 -> D.
  - C: din 0 -> D, din 1 -> A.
  - D: din 0 -> C, din 1 -> B.
  - D means an odd count of 0s and an odd count of 1s since the last clear.
- Async reset (reset_n low):
  - All contexts = A; rr pointer = 0.
  - det_valid = 0, det_ch = 0, det_flag = 0, ctx_is_d = 0.
  - gnt = 0 while reset_n is low.
- Eligibility: eligible[i] = req[i] and not clr[i].
- Arbitration:
  - gnt selects the first eligible channel at or after the pointer, wrapping NCH-1 -> 0. gnt = 0 if none is eligible.
  - Pointer moves to (granted index + 1) mod NCH on a grant. It holds otherwise.
- Service cycle (grant to channel k): context[k] <= next(context[k], din[k]). Next edge sets det_valid = 1, det_ch = k, det_flag = (next == D).
- No grant: det_valid = 0 next cycle. det_ch and det_flag hold their previous values.
- Latency: one cycle from grant to det_valid. Throughput is one bit per cycle total.
- Fairness: with all NCH channels continuously requesting, each is served exactly once every NCH cycles.
- clr[i]:
  - Context[i] <= A at the next edge.
  - Channel i is not granted that cycle. Its pending bit stays pending and is served later from context A.
  - clr on a non-requesting channel simply resets its context.
  - Multiple clr bits may be asserted together.
- ctx_is_d reflects contexts after the edge, so it is consistent with det_flag for det_ch.
- Undefined channel indices (NCH not a power of 2) are never granted.
- Reset mid-stream: every context returns to A. Partial sequences are lost and any in-flight det_valid is dropped.

Decomposition:
- Shared package parity_det_pkg:
  - 2-bit state constants A/B/C/D.
  - Pure next-state function next_ctx(state, bit).
- One sub-module rr_arbiter (NCH parameter): inputs eligible vector and update-enable; outputs one-hot gnt plus encoded index; owns the pointer.
- Context storage, datapath mux and output registers live in the top module.

Test Plan:
- Reset: hold reset_n = 0 with req = 4'b1111 -> gnt = 0. After release, first grant is channel 0, with det_valid = 0 during reset.
- Single channel: channel 2 sends 0,1 on consecutive grants -> det_flag 0 then 1, det_ch = 2, ctx_is_d = 4'b0100 after the second bit.
- Round-robin: req = 4'b1111 held for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, repeated. det_ch sequence 0,1,2,3,0,1,2,3, each lagging its grant by 1 cycle.
- Sparse wrap: pointer at 3, req = 4'b0101 -> grant channel 0, then channel 2, then channel 0.
- Clear collision: channel 1 in D with req[1] = 1 and clr[1] = 1 -> no grant to 1 that cycle and ctx_is_d[1] = 0. On the next cycle, with clr dropped and din = 1, the served result is context C, det_flag = 0.
- Context isolation: interleave channel 0 bits 0,1 and channel 3 bits 1,1 -> channel 0 ends in D (flag 1) and channel 3 ends in A (flag 0), with no cross-corruption.
